// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data memory responder
// Provides the FSM state encoding, data width, default DEPTH/LATENCY and the address-width helper.
package mem_pkg;
    localparam int DATA_W      = 32;
    localparam int DEPTH_DEF   = 32;
    localparam int LATENCY_DEF = 2;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    function automatic int addr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W storage, synchronous write, asynchronous read
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port. Contents are not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = addr_w(DEPTH_DEF)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with fixed latency
// Ports: clk, rst_n (async active-low); request channel req_valid/req_ready/req_ld/req_st/req_addr/req_wdata;
// response channel rsp_valid/rsp_ready/rsp_rdata/rsp_err.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ld,
    input  logic              req_st,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int AW = addr_w(DEPTH);

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              cap_ld, cap_st;
    logic [31:0]       cap_addr;
    logic [DATA_W-1:0] cap_wdata, mem_rdata;
    logic              accept, fire, done, legal;

    assign accept    = state == IDLE && req_valid;
    assign fire      = state == WAIT && cnt == 4'd0;
    assign done      = state == RESP && rsp_ready;
    // exactly one of ld/st, and no address bit at or above AW
    assign legal     = (cap_ld ^ cap_st) && (cap_addr >> AW) == 32'd0;
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;

    always_comb begin
        state_nx = accept ? WAIT : fire ? RESP : done ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_ld    <= 1'b0;
            cap_st    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cap_ld    <= req_ld;
                cap_st    <= req_st;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cnt       <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (fire) begin
                rsp_rdata <= legal && cap_ld ? mem_rdata : '0;
                rsp_err   <= !legal;
            end
        end
    end

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (fire && legal && cap_st),
        .waddr (cap_addr[AW-1:0]),
        .wdata (cap_wdata),
        .raddr (cap_addr[AW-1:0]),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=1 instances)
module tb_data_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ld = 1'b0, req_st = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        v1 = 1'b0, ld1 = 1'b0, st1 = 1'b0, rr1 = 1'b0;
    logic [31:0] a1 = '0, wd1 = '0;
    logic        rdy1, rv1, e1;
    logic [31:0] rd1;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(32), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_ld(req_ld), .req_st(req_st), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
        .req_ld(ld1), .req_st(st1), .req_addr(a1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(e1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // wait for the response, compare against the scoreboard head, then handshake
    task automatic finish_rsp(input string tag);
        int lat;
        logic [32:0] e;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, LAT);
        e = sb.size() > 0 ? sb.pop_front() : 33'h1_DEADBEEF;
        chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 0);
        chk({tag, "_req_ready_back"}, 32'(req_ready), 1);
    endtask

    task automatic op(input string tag, input logic ld, input logic st, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        req_valid = 1'b1; req_ld = ld; req_st = st; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        sb.push_back({exp_e, exp_d});
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_req_ready_busy"}, 32'(req_ready), 0);
        finish_rsp(tag);
    endtask

    task automatic op1(input string tag, input logic ld, input logic st, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_d);
        @(negedge clk);
        v1 = 1'b1; ld1 = ld; st1 = st; a1 = addr; wd1 = wd;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        chk({tag, "_rv_after_N"}, 32'(rv1), 0);
        @(negedge clk);
        chk({tag, "_rv_after_N1"}, 32'(rv1), 1);
        chk({tag, "_rdata"}, rd1, exp_d);
        chk({tag, "_err"}, 32'(e1), 0);
        rr1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rr1 = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        #12;
        chk("reset_req_ready", 32'(req_ready), 1);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", 32'(rsp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        op("st24", 0, 1, 24, 32'hFFFFFFFF, 0, 0);
        op("ld24", 1, 0, 24, 0, 32'hFFFFFFFF, 0);
        op("st20", 0, 1, 20, 32'hFFFFFFE3, 0, 0);
        op("ld24b", 1, 0, 24, 0, 32'hFFFFFFFF, 0);
        op("ld20", 1, 0, 20, 0, 32'hFFFFFFE3, 0);

        // stall the response for 5 cycles while a stray store to addr 24 is offered
        @(negedge clk);
        req_valid = 1'b1; req_ld = 1'b1; req_st = 1'b0; req_addr = 20;
        @(posedge clk);
        sb.push_back({1'b0, 32'hFFFFFFE3});
        @(negedge clk);
        req_ld = 1'b0; req_st = 1'b1; req_addr = 24; req_wdata = 32'h0;
        while (!rsp_valid) @(negedge clk);
        held = rsp_rdata;
        chk("stall_first_rdata", held, 32'hFFFFFFE3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 1);
            chk("stall_rdata", rsp_rdata, held);
            chk("stall_err", 32'(rsp_err), 0);
            chk("stall_req_ready", 32'(req_ready), 0);
        end
        void'(sb.pop_front());
        req_ld = 1'b1; req_st = 1'b0; req_addr = 24;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_idle_rsp_valid", 32'(rsp_valid), 0);
        chk("release_idle_req_ready", 32'(req_ready), 1);
        @(posedge clk);
        sb.push_back({1'b0, 32'hFFFFFFFF});
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("release_accepted", 32'(req_ready), 0);
        finish_rsp("after_stall_ld24");

        // illegal requests
        op("st0", 0, 1, 0, 32'h0BADF00D, 0, 0);
        op("ill_both", 1, 1, 3, 32'hCAFEBABE, 0, 1);
        op("ill_none", 0, 0, 3, 32'hCAFEBABE, 0, 1);
        op("ill_addr", 0, 1, 32, 32'h12345678, 0, 1);
        op("ill_hi", 1, 0, 32'h8000_0001, 0, 0, 1);
        op("ld0", 1, 0, 0, 0, 32'h0BADF00D, 0);

        // reset in the middle of a store
        op("st5", 0, 1, 5, 32'h11111111, 0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_ld = 1'b0; req_st = 1'b1; req_addr = 5; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mid_req_ready", 32'(req_ready), 1);
        chk("rst_mid_rdata", rsp_rdata, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        op("ld5", 1, 0, 5, 0, 32'h11111111, 0);

        // LATENCY=1 instance
        op1("l1_st1", 0, 1, 1, 32'h00C0FFEE, 0);
        op1("l1_ld1", 1, 0, 1, 0, 32'h00C0FFEE);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 32, number of 32-bit data words (power of two, 2..1024).
REQ-002 Parameter LATENCY, default 2, cycles from request accept to response valid (1..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  requester presents a memory operation.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_ld  input  1  operation is a load.
REQ-008 req_st  input  1  operation is a store.
REQ-009 req_addr  input  32  word address (MAR).
REQ-010 req_wdata  input  32  store data (MDR).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  requester accepts the response.
REQ-013 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was illegal; no memory effect.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, req_valid=1 SHALL accept on that edge: capture req_ld, req_st, req_addr, req_wdata; load the latency counter with LATENCY-1; go to WAIT.
REQ-017 In IDLE, req_valid=0 SHALL leave the FSM in IDLE.
REQ-018 Request inputs SHALL be ignored outside IDLE.
REQ-019 WAIT SHALL decrement the counter each cycle; at counter 0 it SHALL perform the operation and go to RESP, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 A legal store SHALL write the captured wdata to mem[addr] on the WAIT-exit edge; rsp_rdata=0, rsp_err=0.
REQ-021 A legal load SHALL register mem[addr] into rsp_rdata on the WAIT-exit edge; rsp_err=0.
REQ-022 Illegal conditions: req_ld and req_st both 1, both 0, or req_addr >= DEPTH (any bit above log2(DEPTH)-1 set). Each SHALL give rsp_err=1, rsp_rdata=0, with no memory write and the same latency.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid and rsp_ready are both 1 on an edge; that edge SHALL return to IDLE with rsp_valid=0.
REQ-024 rsp_ready=1 outside RESP SHALL have no effect; a request SHALL NOT be accepted on the same edge as the response handshake (minimum 1 IDLE cycle between operations).
REQ-025 Memory SHALL retain contents across operations; only legal stores modify it.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
REQ-027 A store not yet committed when reset asserts SHALL be discarded; memory array contents SHALL NOT be reset (undefined until written).

Structure
REQ-028 Shared package mem_pkg SHALL hold the FSM state encoding, DATA_W=32, the DEPTH and LATENCY defaults, and the address-width function.
REQ-029 Storage SHALL be one sub-module mem_array (DEPTH x 32, one synchronous write port, one read port) instantiated by data_mem_responder.

Verification
REQ-030 Store 0xFFFFFFFF at addr 24, then load addr 24 -> rsp_rdata=0xFFFFFFFF, rsp_err=0, rsp_valid exactly 2 cycles after accept.
REQ-031 Store 0xFFFFFFE3 at addr 20, then load addr 24 and addr 20 -> 0xFFFFFFFF and 0xFFFFFFE3 (no aliasing).
REQ-032 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0, a new req_valid is ignored; on release, one IDLE cycle, then accept.
REQ-033 Illegal requests: ld=st=1 at addr 3; ld=st=0; store 0x12345678 at addr 32 -> each rsp_err=1, rsp_rdata=0; a later load of addr 0 returns the prior contents of addr 0.
REQ-034 Assert rst_n=0 mid-WAIT of a store of 0xA5A5A5A5 to addr 5 (addr 5 preloaded with 0x11111111) -> rsp_valid=0 and req_ready=1 immediately; a later load of addr 5 returns 0x11111111.
REQ-035 LATENCY=1 build: load accepted at edge N -> rsp_valid=1 after edge N+1.
